float_mul: RTL and testbench



---
 rtl/fmul_pkg.sv | 33 +++
 rtl/fmul_round_pack.sv | 62 ++++++
 rtl/float_mul.sv | 142 ++++++++++++++
 tb/tb_float_mul.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// Shared types, constants and helpers for the binary32 multiplier.
package fmul_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_t;

  function automatic fp_class_t classify(input fp32_t x);
    if (x.exp == EXP_MAX) return (x.frac != 23'd0) ? NAN : INF;
    if (x.exp == 8'd0)    return (x.frac != 23'd0) ? SUB : ZERO;
    return NORM;
  endfunction

  // Leading-zero count of a 24-bit significand; the last hit in the scan is the top set bit.
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fmul_round_pack.sv
// Final stage: normalise the 48-bit significand product, round to nearest-even,
// resolve overflow/underflow and pack the binary32 result.
module fmul_round_pack
  import fmul_pkg::*;
(
  input  logic [47:0]       prod,
  input  logic signed [9:0] exp_in,
  input  logic              sign,
  input  logic              spec,
  input  logic [31:0]       spec_val,
  output logic [31:0]       result
);

  logic [47:0]       norm;
  logic signed [9:0] e;
  logic signed [9:0] e_final;
  logic              tiny;
  logic              lost;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [23:0]       mant;
  logic [24:0]       rounded;
`ifdef FMUL_DENORM_EN
  logic [9:0]        shamt;
`endif

  always_comb begin
    norm = prod[47] ? prod : {prod[46:0], 1'b0};
    e    = exp_in + (prod[47] ? 10'sd1 : 10'sd0);
    tiny = 1'b0;
    lost = 1'b0;
`ifdef FMUL_DENORM_EN
    shamt = '0;
    // Tiny results are denormalised before rounding; shifted-out bits feed sticky.
    if (e <= 10'sd0) begin
      tiny  = 1'b1;
      shamt = 10'(10'sd1 - e);
      lost  = |(norm & ~({48{1'b1}} << shamt));
      norm  = norm >> shamt;
    end
`endif
    mant     = norm[47:24];
    guard    = norm[23];
    sticky   = (|norm[22:0]) | lost;
    round_up = guard & (sticky | mant[0]);
    rounded  = {1'b0, mant} + {24'b0, round_up};
    e_final  = e + $signed({9'b0, rounded[24]});

    if (spec)
      result = spec_val;
    else if (tiny)
      result = {sign, 7'b0, rounded[23:0]};
    else if (e_final >= 10'sd255)
      result = {sign, POS_INF[30:0]};
    else if (e_final <= 10'sd0)
      result = {sign, 31'b0};
    else
      result = {sign, e_final[7:0], rounded[24] ? rounded[23:1] : rounded[22:0]};
  end

endmodule

// File: rtl/float_mul.sv
// Three-stage pipelined binary32 multiplier with round-to-nearest-even.
// Define FMUL_DENORM_EN to keep subnormal operands/results instead of flushing to zero.
module float_mul
  import fmul_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] out
);

  if (LATENCY != 3) begin : g_bad_latency
    $error("float_mul: LATENCY is fixed at 3");
  end

  logic [1:0][31:0] ops;
  logic [1:0]       op_nan;
  logic [1:0]       op_inf;
  logic [1:0]       op_zero;
  logic [1:0][23:0] op_sig;
  logic [1:0][9:0]  op_exp;

  assign ops = {num2, num1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    fp32_t             x;
    fp_class_t         cls;
    logic [23:0]       sig;
    logic signed [9:0] exp_eff;

    assign x   = ops[gi];
    assign cls = classify(x);

    always_comb begin
`ifdef FMUL_DENORM_EN
      // Subnormals: hidden bit 0, exponent 1, then left-normalise so S2 sees bit 23 set.
      if (cls == SUB) begin
        sig     = {1'b0, x.frac} << lzc24({1'b0, x.frac});
        exp_eff = 10'sd1 - $signed({5'b0, lzc24({1'b0, x.frac})});
      end else begin
        sig     = {1'b1, x.frac};
        exp_eff = $signed({2'b0, x.exp});
      end
`else
      sig     = {1'b1, x.frac};
      exp_eff = $signed({2'b0, x.exp});
`endif
    end

    assign op_nan[gi] = (cls == NAN);
    assign op_inf[gi] = (cls == INF);
`ifdef FMUL_DENORM_EN
    assign op_zero[gi] = (cls == ZERO);
`else
    assign op_zero[gi] = (cls == ZERO) || (cls == SUB);
`endif
    assign op_sig[gi] = sig;
    assign op_exp[gi] = exp_eff;
  end

  logic              sign;
  logic              spec;
  logic [31:0]       spec_val;
  logic signed [9:0] exp_sum;

  always_comb begin
    sign     = num1[31] ^ num2[31];
    spec     = 1'b1;
    spec_val = QNAN;
    if (|op_nan)
      spec_val = QNAN;
    else if ((op_inf[0] & op_zero[1]) | (op_inf[1] & op_zero[0]))
      spec_val = QNAN;
    else if (|op_inf)
      spec_val = {sign, POS_INF[30:0]};
    else if (|op_zero)
      spec_val = {sign, 31'b0};
    else begin
      spec     = 1'b0;
      spec_val = '0;
    end
    exp_sum = $signed(op_exp[0]) + $signed(op_exp[1]) - $signed(10'(EXP_BIAS));
  end

  logic              s1_sign_reg;
  logic              s1_spec_reg;
  logic [31:0]       s1_spec_val_reg;
  logic signed [9:0] s1_exp_reg;
  logic [23:0]       s1_sig_a_reg;
  logic [23:0]       s1_sig_b_reg;

  logic              s2_sign_reg;
  logic              s2_spec_reg;
  logic [31:0]       s2_spec_val_reg;
  logic signed [9:0] s2_exp_reg;
  logic [47:0]       s2_prod_reg;

  logic [31:0]       packed_result;

  fmul_round_pack u_round_pack (
    .prod     (s2_prod_reg),
    .exp_in   (s2_exp_reg),
    .sign     (s2_sign_reg),
    .spec     (s2_spec_reg),
    .spec_val (s2_spec_val_reg),
    .result   (packed_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign_reg     <= 1'b0;
      s1_spec_reg     <= 1'b0;
      s1_spec_val_reg <= '0;
      s1_exp_reg      <= '0;
      s1_sig_a_reg    <= '0;
      s1_sig_b_reg    <= '0;
      s2_sign_reg     <= 1'b0;
      s2_spec_reg     <= 1'b0;
      s2_spec_val_reg <= '0;
      s2_exp_reg      <= '0;
      s2_prod_reg     <= '0;
      out             <= '0;
    end else begin
      s1_sign_reg     <= sign;
      s1_spec_reg     <= spec;
      s1_spec_val_reg <= spec_val;
      s1_exp_reg      <= exp_sum;
      s1_sig_a_reg    <= op_sig[0];
      s1_sig_b_reg    <= op_sig[1];
      s2_sign_reg     <= s1_sign_reg;
      s2_spec_reg     <= s1_spec_reg;
      s2_spec_val_reg <= s1_spec_val_reg;
      s2_exp_reg      <= s1_exp_reg;
      s2_prod_reg     <= s1_sig_a_reg * s1_sig_b_reg;
      out             <= packed_result;
    end
  end

endmodule

// File: tb/tb_float_mul.sv
// Randomised check of float_mul against a real-arithmetic reference model.
// Honours FMUL_DENORM_EN the same way as the design build.
module tb_float_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] num1 = '0;
  logic [31:0] num2 = '0;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  float_mul dut (
    .clk  (clk),
    .rst  (rst),
    .num1 (num1),
    .num2 (num2),
    .out  (out)
  );

  // Magnitude of a finite binary32 as a real (exact in double precision).
  function automatic real mag_of(input logic [31:0] x);
    int          e;
    int          m;
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e == 0) return real'(m) * (2.0 ** real'(-149));
    return real'(m + (1 << 23)) * (2.0 ** real'(e - 150));
  endfunction

  // Round a positive exact real product to binary32 with ties-to-even.
  function automatic logic [31:0] round_f32(input logic s, input real p);
    logic [63:0]     bits;
    longint unsigned m, q, rem, half;
    int              fe, sh;
    bits = $realtobits(p);
    fe   = int'(bits[62:52]) - 1023 + 127;
    m    = {11'b0, 1'b1, bits[51:0]};
    sh   = 29;
`ifdef FMUL_DENORM_EN
    if (fe <= 0) begin
      sh = 30 - fe;
      if (sh > 62) return {s, 31'b0};
    end
`endif
    q    = m >> sh;
    rem  = m - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
`ifdef FMUL_DENORM_EN
    if (fe <= 0) return {s, q[30:0]};
`endif
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      fe = fe + 1;
    end
    if (fe >= 255) return {s, 31'h7F800000};
    if (fe <= 0)   return {s, 31'b0};
    return {s, fe[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
`ifdef FMUL_DENORM_EN
    a_zero = (a[30:0] == 0);
    b_zero = (b[30:0] == 0);
`else
    a_zero = (a[30:23] == 0);
    b_zero = (b[30:23] == 0);
`endif
    if (a_nan || b_nan) return 32'h7FC00000;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
    if (a_inf || b_inf) return {s, 31'h7F800000};
    if (a_zero || b_zero) return {s, 31'b0};
    return round_f32(s, mag_of(a) * mag_of(b));
  endfunction

  // Sampled inputs at each rising edge; out after edge N reflects edge N-2.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
  } samp_t;
  samp_t hist[$];

  always @(posedge clk) begin
    hist.push_back('{num1, num2, rst});
    if (hist.size() > 3) void'(hist.pop_front());
  end

  always @(negedge clk) begin
    logic [31:0] expv;
    if (hist.size() == 3) begin
      if (hist[0].r || hist[1].r || hist[2].r) expv = 32'h0;
      else expv = model_mul(hist[0].a, hist[0].b);
      checks++;
      if (out !== expv) begin
        errors++;
        $display("FAIL pipe_out t=%0t a=%h b=%h rst_win=%b%b%b got=%h expected=%h",
                 $time, hist[0].a, hist[0].b, hist[0].r, hist[1].r, hist[2].r, out, expv);
      end
    end
  end

  localparam int NDIR = 13;
  localparam logic [31:0] DIR_A [NDIR] = '{
    32'h7F800000, 32'h00000000, 32'h40000000, 32'h41200000, 32'h42800000,
    32'h7FC00002, 32'h7F000000, 32'h00800000, 32'h3F800001, 32'h80000000,
    32'hFF800000, 32'h3F800000, 32'h00000001};
  localparam logic [31:0] DIR_B [NDIR] = '{
    32'h01E51000, 32'h7F800000, 32'h447A0000, 32'hC2C60000, 32'h40000002,
    32'h180100E0, 32'h40000000, 32'h3F000000, 32'h3F800001, 32'h3F800000,
    32'h40000000, 32'hBF800000, 32'h3F800000};
`ifdef FMUL_DENORM_EN
  localparam logic [31:0] DIR_E [NDIR] = '{
    32'h7F800000, 32'h7FC00000, 32'h44FA0000, 32'hC4778000, 32'h43000002,
    32'h7FC00000, 32'h7F800000, 32'h00400000, 32'h3F800002, 32'h80000000,
    32'hFF800000, 32'hBF800000, 32'h00000001};
`else
  localparam logic [31:0] DIR_E [NDIR] = '{
    32'h7F800000, 32'h7FC00000, 32'h44FA0000, 32'hC4778000, 32'h43000002,
    32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h3F800002, 32'h80000000,
    32'hFF800000, 32'hBF800000, 32'h00000000};
`endif

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    logic [31:0] f;
    r = $urandom;
    f = $urandom;
    case ($urandom_range(0, 9))
      0: return r;
      1: case ($urandom_range(0, 5))
           0: return 32'h00000000;
           1: return 32'h80000000;
           2: return {r[31], 31'h7F800000};
           3: return 32'h7FC00000;
           default: return {r[31], 8'hFF, f[22:0] | 23'd1};
         endcase
      2: return {r[31], 8'h00, f[22:0]};
      3, 4: return {r[31], 8'($urandom_range(107, 147)), f[22:0]};
      5: return {r[31], 8'($urandom_range(1, 70)), f[22:0]};
      6: return {r[31], 8'($urandom_range(180, 254)), f[22:0]};
      7: return {r[31], 8'($urandom_range(100, 150)), f[22:11], 10'b0, f[0]};
      8: return {r[31], 8'($urandom_range(100, 150)), 23'h7FFFFF - 23'(f[2:0])};
      default: return {r[31], 8'($urandom_range(1, 254)), f[22:0]};
    endcase
  endfunction

  initial begin
    logic [31:0] m;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Directed vectors back-to-back; each also pins the model to a hand-worked value.
    for (int i = 0; i < NDIR; i++) begin
      num1 = DIR_A[i];
      num2 = DIR_B[i];
      m = model_mul(DIR_A[i], DIR_B[i]);
      checks++;
      if (m !== DIR_E[i]) begin
        errors++;
        $display("FAIL model_vec%0d a=%h b=%h got=%h expected=%h", i, DIR_A[i], DIR_B[i], m, DIR_E[i]);
      end
      $display("vec %0d: %h x %h -> expect %h", i, DIR_A[i], DIR_B[i], DIR_E[i]);
      @(negedge clk);
    end

    for (int i = 0; i < 1500; i++) begin
      num1 = rand_op();
      num2 = rand_op();
      rst  = (i == 600) || (i == 1100) || (i == 1101);
      @(negedge clk);
    end
    rst  = 1'b0;
    num1 = '0;
    num2 = '0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
